// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core, debug/loader)
// and the single-port DM. The arbiter uses the slave modport; requesters/DM use master.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wd;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output dm_addr, dm_wd, dm_we,
        input  dm_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  dm_addr, dm_wd, dm_we,
        output dm_rd
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single-port 32-word DM between the core and the debug/loader port with
// ownership and a bounded contested burst. Optional DM_ARB_LOCK_EN adds dbg_lock.
//
// state     | meaning
// S_IDLE    | no owner, CPU wins a tie
// S_OWN_CPU | CPU owns the memory, keeps it for up to MAX_BURST contested grants
// S_OWN_DBG | debug port owns the memory (dbg_lock pins ownership when enabled)
module dm_port_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef DM_ARB_LOCK_EN
    input  logic               dbg_lock,
`endif
    dm_port_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN_CPU, S_OWN_DBG} state_t;

    state_t            r_state, w_state_nxt, w_oth_state;
    logic [CNT_W-1:0]  r_burst, w_burst_nxt;
    logic              w_lock, w_own_is_cpu, w_own_req, w_oth_req;
    logic              w_take_own, w_take_oth, w_take_cpu, w_take_dbg;
    logic              w_gnt_cpu, w_gnt_dbg, w_rd_cpu, w_rd_dbg;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [DATA_W-1:0] r_dm_wd;
    logic              r_cpu_rvalid, r_dbg_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata, r_dbg_rdata;

`ifdef DM_ARB_LOCK_EN
    assign w_lock = dbg_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_own_is_cpu = (r_state == S_OWN_CPU);
    assign w_own_req    = w_own_is_cpu ? bus.cpu_req : bus.dbg_req;
    assign w_oth_req    = w_own_is_cpu ? bus.dbg_req : bus.cpu_req;
    assign w_oth_state  = w_own_is_cpu ? S_OWN_DBG : S_OWN_CPU;

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_take_own  = 1'b0;
        w_take_oth  = 1'b0;
        w_take_cpu  = 1'b0;
        w_take_dbg  = 1'b0;
        if (r_state == S_IDLE) begin
            w_burst_nxt = '0;
            if (bus.cpu_req) begin
                w_take_cpu  = 1'b1;
                w_state_nxt = S_OWN_CPU;
            end else if (bus.dbg_req) begin
                w_take_dbg  = 1'b1;
                w_state_nxt = S_OWN_DBG;
            end
        end else if (r_state == S_OWN_DBG && w_lock) begin
            // locked: CPU is stalled, counter frozen until the lock drops
            w_take_dbg = bus.dbg_req;
            if (!bus.cpu_req && !bus.dbg_req) begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = '0;
            end
        end else if (w_own_req && w_oth_req) begin
            if (r_burst < CNT_W'(MAX_BURST)) begin
                w_take_own  = 1'b1;
                w_burst_nxt = r_burst + CNT_W'(1);
            end else begin
                w_take_oth  = 1'b1;
                w_state_nxt = w_oth_state;
                w_burst_nxt = CNT_W'(1);
            end
        end else if (w_own_req) begin
            w_take_own  = 1'b1;
            w_burst_nxt = '0;
        end else if (w_oth_req) begin
            w_take_oth  = 1'b1;
            w_state_nxt = w_oth_state;
            w_burst_nxt = '0;
        end else begin
            w_state_nxt = S_IDLE;
            w_burst_nxt = '0;
        end
    end

    // grants are masked while reset is asserted so nothing reaches the DM
    assign w_gnt_cpu = reset & (w_take_cpu | (w_own_is_cpu ? w_take_own : w_take_oth));
    assign w_gnt_dbg = reset & (w_take_dbg | (w_own_is_cpu ? w_take_oth : w_take_own));
    assign w_rd_cpu  = w_gnt_cpu & ~bus.cpu_we;
    assign w_rd_dbg  = w_gnt_dbg & ~bus.dbg_we;

    assign bus.cpu_gnt    = w_gnt_cpu;
    assign bus.dbg_gnt    = w_gnt_dbg;
    assign bus.dm_we      = (w_gnt_cpu & bus.cpu_we) | (w_gnt_dbg & bus.dbg_we);
    assign bus.dm_addr    = w_gnt_cpu ? bus.cpu_addr  : (w_gnt_dbg ? bus.dbg_addr  : r_dm_addr);
    assign bus.dm_wd      = w_gnt_cpu ? bus.cpu_wdata : (w_gnt_dbg ? bus.dbg_wdata : r_dm_wd);
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_burst      <= '0;
            r_dm_addr    <= '0;
            r_dm_wd      <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst      <= w_burst_nxt;
            r_cpu_rvalid <= w_rd_cpu;
            r_dbg_rvalid <= w_rd_dbg;
            if (w_gnt_cpu || w_gnt_dbg) begin
                r_dm_addr <= bus.dm_addr;
                r_dm_wd   <= bus.dm_wd;
            end
            if (w_rd_cpu) r_cpu_rdata <= bus.dm_rd;
            if (w_rd_dbg) r_dbg_rdata <= bus.dm_rd;
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter against an ownership/burst reference model
// plus a shadow memory; directed sequences cover reset, latency and burst limits.
module tb_dm_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef DM_ARB_LOCK_EN
    logic dbg_lock;
`endif

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef DM_ARB_LOCK_EN
        .dbg_lock (dbg_lock),
`endif
        .bus      (bus.slave)
    );

    // DM instance stand-in: combinational read, clocked write
    logic [DW-1:0] mem [32];
    assign bus.dm_rd = mem[bus.dm_addr];
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wd;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // requester state, index 1 = cpu, 2 = dbg
    logic          q_req [3];
    logic          q_we  [3];
    logic [AW-1:0] q_addr[3];
    logic [DW-1:0] q_wd  [3];

    // reference model
    int            own, cnt, obs_g;
    logic [DW-1:0] ref_mem [32];
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rv [3];
    logic [DW-1:0] e_rd [3];

    task automatic model_reset();
        own = 0; cnt = 0; e_addr = '0; e_wd = '0;
        for (int p = 1; p <= 2; p++) begin e_rv[p] = 1'b0; e_rd[p] = '0; end
    endtask

    task automatic drive();
        bus.cpu_req = q_req[1]; bus.cpu_we = q_we[1]; bus.cpu_addr = q_addr[1]; bus.cpu_wdata = q_wd[1];
        bus.dbg_req = q_req[2]; bus.dbg_we = q_we[2]; bus.dbg_addr = q_addr[2]; bus.dbg_wdata = q_wd[2];
    endtask

    task automatic new_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        q_req[p] = 1'b1; q_we[p] = we; q_addr[p] = a; q_wd[p] = d;
    endtask

    task automatic rnd_req(input int p);
        new_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
    endtask

    // one cycle: called just after negedge, returns just after the next negedge
    task automatic step(output int g);
        int w;
        logic lk;
        drive();
        lk = 1'b0;
`ifdef DM_ARB_LOCK_EN
        lk = dbg_lock;
`endif
        w = 0;
        if (own == 0) begin
            w = q_req[1] ? 1 : (q_req[2] ? 2 : 0);
            own = w; cnt = 0;
        end else if (own == 2 && lk) begin
            w = q_req[2] ? 2 : 0;
            if (!q_req[1] && !q_req[2]) begin own = 0; cnt = 0; end
        end else if (q_req[1] && q_req[2]) begin
            if (cnt < MB) begin w = own; cnt++; end
            else begin w = 3 - own; own = w; cnt = 1; end
        end else if (q_req[own]) begin
            w = own; cnt = 0;
        end else if (q_req[3 - own]) begin
            w = 3 - own; own = w; cnt = 0;
        end else begin
            own = 0; cnt = 0;
        end
        #1;
        obs_g = bus.cpu_gnt ? 1 : (bus.dbg_gnt ? 2 : 0);
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(w == 1));
        chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(w == 2));
        chk("one_gnt", 32'(bus.cpu_gnt & bus.dbg_gnt), 32'd0);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_rv[1]));
        chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e_rv[2]));
        chk("cpu_rdata", bus.cpu_rdata, e_rd[1]);
        chk("dbg_rdata", bus.dbg_rdata, e_rd[2]);
        if (w != 0) begin e_addr = q_addr[w]; e_wd = q_wd[w]; end
        chk("dm_we", 32'(bus.dm_we), 32'(w != 0 && q_we[w]));
        chk("dm_addr", 32'(bus.dm_addr), 32'(e_addr));
        chk("dm_wd", bus.dm_wd, e_wd);
        for (int p = 1; p <= 2; p++) begin
            e_rv[p] = (w == p) && !q_we[p];
            if (e_rv[p]) e_rd[p] = ref_mem[q_addr[p]];
        end
        if (w != 0 && q_we[w]) ref_mem[q_addr[w]] = q_wd[w];
        if (w != 0) q_req[w] = 1'b0;
        g = w;
        @(negedge clk);
    endtask

    int g, n, got;

    initial begin
        reset = 1'b0;
`ifdef DM_ARB_LOCK_EN
        dbg_lock = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        for (int p = 0; p < 3; p++) begin q_req[p] = 0; q_we[p] = 0; q_addr[p] = '0; q_wd[p] = '0; end
        model_reset();
        drive();
        @(negedge clk);
        chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        chk("rst_dm_wd", bus.dm_wd, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // cpu read of a known word
        mem[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
        new_req(1, 1'b0, AW'(3), 32'h0);
        step(g);
        #1;
        chk("t2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t2_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("t2_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        // dbg write then cpu readback
        new_req(2, 1'b1, AW'(7), 32'h12345678);
        step(g);
        step(g);
        new_req(1, 1'b0, AW'(7), 32'h0);
        step(g);
        #1;
        chk("t3_readback", bus.cpu_rdata, 32'h12345678);

        // reset asserted mid-read, before the capturing edge
        @(negedge clk);
        new_req(1, 1'b0, AW'(3), 32'h0);
        drive();
        #1;
        chk("t1_gnt_pre", 32'(bus.cpu_gnt), 32'd1);
        reset = 1'b0;
        #1;
        chk("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("t1_dm_we", 32'(bus.dm_we), 32'd0);
        chk("t1_dm_addr", 32'(bus.dm_addr), 32'd0);
        chk("t1_dm_wd", bus.dm_wd, 32'd0);
        chk("t1_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("t1_dbg_rdata", bus.dbg_rdata, 32'd0);
        @(negedge clk);
        q_req[1] = 1'b0;
        drive();
        reset = 1'b1;
        #1;
        chk("t1_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        model_reset();
        @(negedge clk);

        // both requesting continuously from IDLE: C x5, then D x4, C x4, ...
        step(g);
        for (int i = 0; i < 21; i++) begin
            if (!q_req[1]) rnd_req(1);
            if (!q_req[2]) rnd_req(2);
            step(g);
            chk("t4_pattern", 32'(obs_g), (i < 5) ? 32'd1 : ((((i - 5) / 4) % 2 == 0) ? 32'd2 : 32'd1));
        end
        q_req[1] = 1'b0; q_req[2] = 1'b0;
        step(g);

        // cpu alone, then dbg joins
        for (int i = 0; i < 20; i++) begin
            rnd_req(1);
            step(g);
            chk("t5_cpu_only", 32'(obs_g), 32'd1);
        end
        rnd_req(2);
        n = 0; got = 0;
        for (int i = 0; i < MB + 3 && got == 0; i++) begin
            if (!q_req[1]) rnd_req(1);
            step(g);
            if (obs_g == 2) got = 1; else n++;
        end
        chk("t5_dbg_granted", 32'(got), 32'd1);
        chk("t5_cpu_before_dbg", 32'(n), 32'(MB));
        q_req[1] = 1'b0; q_req[2] = 1'b0;
        step(g);

`ifdef DM_ARB_LOCK_EN
        rnd_req(2);
        step(g);
        dbg_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!q_req[1]) rnd_req(1);
            if (!q_req[2]) rnd_req(2);
            step(g);
            chk("t6_locked_dbg", 32'(obs_g), 32'd2);
        end
        dbg_lock = 1'b0;
        n = 0; got = 0;
        for (int i = 0; i < MB + 3 && got == 0; i++) begin
            if (!q_req[1]) rnd_req(1);
            if (!q_req[2]) rnd_req(2);
            step(g);
            if (obs_g == 1) got = 1; else n++;
        end
        chk("t6_cpu_granted", 32'(got), 32'd1);
        chk("t6_wait_bound", 32'(n <= MB), 32'd1);
        q_req[1] = 1'b0; q_req[2] = 1'b0;
        step(g);
`endif

        // random traffic with withdrawals
        for (int i = 0; i < 800; i++) begin
            for (int p = 1; p <= 2; p++) begin
                if (!q_req[p]) begin
                    if ($urandom_range(0, 2) != 0) rnd_req(p);
                end else if ($urandom_range(0, 15) == 0) begin
                    q_req[p] = 1'b0;
                end
            end
`ifdef DM_ARB_LOCK_EN
            if ($urandom_range(0, 5) == 0) dbg_lock = ~dbg_lock;
`endif
            step(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
